reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 15 +
 rtl/reorder_buffer.sv | 171 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the ROB and the units that consume its tags
// (reservation stations, load/store unit).
package reorder_buffer_pkg;

  localparam int ROB_WIDTH  = 4;
  localparam int ROB_SIZE   = 15;
  localparam int DATA_WIDTH = 32;

  // Tag 0 is reserved to mean "operand has no producer in flight".
  localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue of in-flight results indexed by tag
// 1..ROB_SIZE. Captures ALU and load/store CDB broadcasts, forwards
// operands to lookup ports, and retires one ready head entry per cycle.
module reorder_buffer
  import reorder_buffer_pkg::DATA_WIDTH, reorder_buffer_pkg::TRUE, reorder_buffer_pkg::FALSE;
#(
  parameter int ROB_SIZE  = reorder_buffer_pkg::ROB_SIZE,
  parameter int ROB_WIDTH = reorder_buffer_pkg::ROB_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  clear,
  input  logic                  alloc_ena,
  input  logic [4:0]            alloc_rd,
  output logic [ROB_WIDTH-1:0]  alloc_tag,
  output logic                  has_capacity,
  input  logic [ROB_WIDTH-1:0]  alu_cdb_tag,
  input  logic [DATA_WIDTH-1:0] alu_cdb_data,
  input  logic                  alu_cdb_isload,
  input  logic [ROB_WIDTH-1:0]  ls_cdb_tag,
  input  logic [DATA_WIDTH-1:0] ls_cdb_data,
  input  logic [ROB_WIDTH-1:0]  q1_tag,
  input  logic [ROB_WIDTH-1:0]  q2_tag,
  output logic                  q1_ready,
  output logic                  q2_ready,
  output logic [DATA_WIDTH-1:0] q1_data,
  output logic [DATA_WIDTH-1:0] q2_data,
  output logic                  commit_ena,
  output logic [4:0]            commit_rd,
  output logic [DATA_WIDTH-1:0] commit_data,
  output logic [ROB_WIDTH-1:0]  commit_tag
);

  localparam int CW = $clog2(ROB_SIZE + 1);
  localparam logic [ROB_WIDTH-1:0] TAG_ONE = ROB_WIDTH'(1);
  localparam logic [ROB_WIDTH-1:0] TAG_MAX = ROB_WIDTH'(ROB_SIZE);

  // Entry 0 exists only so tags index directly; it is never allocated.
  logic [ROB_SIZE:0]                 busy_q, busy_d, rdy_q, rdy_d;
  logic [ROB_SIZE:0][4:0]            rd_q, rd_d;
  logic [ROB_SIZE:0][DATA_WIDTH-1:0] val_q, val_d;
  logic [ROB_WIDTH-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic                              cm_ena_q, cm_ena_d;
  logic [4:0]                        cm_rd_q, cm_rd_d;
  logic [DATA_WIDTH-1:0]             cm_data_q, cm_data_d;
  logic [ROB_WIDTH-1:0]              cm_tag_q, cm_tag_d;

  logic alu_hit, ls_hit, commit_fire, alloc_fire;

  // Pointers wrap ROB_SIZE -> 1 and never hold 0.
  function automatic logic [ROB_WIDTH-1:0] next_ptr(input logic [ROB_WIDTH-1:0] p);
    return (p == TAG_MAX) ? TAG_ONE : p + TAG_ONE;
  endfunction

  // Stored value first, then same-cycle ls broadcast, then ALU broadcast.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ROB_WIDTH-1:0] t);
    logic [DATA_WIDTH:0] r;
    r = '0;
    if (t == '0)                                  r = {TRUE, {DATA_WIDTH{1'b0}}};
    else if (t <= TAG_MAX && rdy_q[t])            r = {TRUE, val_q[t]};
    else if (ls_cdb_tag == t)                     r = {TRUE, ls_cdb_data};
    else if (alu_cdb_tag == t && !alu_cdb_isload) r = {TRUE, alu_cdb_data};
    return r;
  endfunction

  assign alloc_tag    = tail_q;
  assign has_capacity = (cnt_q < CW'(ROB_SIZE));
  assign commit_ena   = cm_ena_q;
  assign commit_rd    = cm_rd_q;
  assign commit_data  = cm_data_q;
  assign commit_tag   = cm_tag_q;

  // Readiness uses pre-edge state, so a same-cycle CDB write never commits.
  assign alu_hit     = (alu_cdb_tag != '0) && (alu_cdb_tag <= TAG_MAX) && !alu_cdb_isload && busy_q[alu_cdb_tag];
  assign ls_hit      = (ls_cdb_tag != '0) && (ls_cdb_tag <= TAG_MAX) && busy_q[ls_cdb_tag];
  assign commit_fire = ena && !clear && busy_q[head_q] && rdy_q[head_q];
  assign alloc_fire  = ena && alloc_ena && has_capacity && !clear;

  // Operand lookup ports.
  always_comb begin
    {q1_ready, q1_data} = lookup(q1_tag);
    {q2_ready, q2_data} = lookup(q2_tag);
  end

  // Next-state: flush, CDB capture (ls last so it wins), commit, allocate.
  always_comb begin
    busy_d    = busy_q;
    rdy_d     = rdy_q;
    rd_d      = rd_q;
    val_d     = val_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    cm_ena_d  = cm_ena_q;
    cm_rd_d   = cm_rd_q;
    cm_data_d = cm_data_q;
    cm_tag_d  = cm_tag_q;
    if (ena) begin
      if (clear) begin
        busy_d   = '0;
        rdy_d    = '0;
        head_d   = TAG_ONE;
        tail_d   = TAG_ONE;
        cnt_d    = '0;
        cm_ena_d = FALSE;
      end else begin
        cm_ena_d = FALSE;
        if (alu_hit) begin
          rdy_d[alu_cdb_tag] = TRUE;
          val_d[alu_cdb_tag] = alu_cdb_data;
        end
        if (ls_hit) begin
          rdy_d[ls_cdb_tag] = TRUE;
          val_d[ls_cdb_tag] = ls_cdb_data;
        end
        if (commit_fire) begin
          cm_ena_d       = TRUE;
          cm_rd_d        = rd_q[head_q];
          cm_data_d      = val_q[head_q];
          cm_tag_d       = head_q;
          busy_d[head_q] = FALSE;
          rdy_d[head_q]  = FALSE;
          head_d         = next_ptr(head_q);
        end
        if (alloc_fire) begin
          busy_d[tail_q] = TRUE;
          rdy_d[tail_q]  = FALSE;
          rd_d[tail_q]   = alloc_rd;
          tail_d         = next_ptr(tail_q);
        end
        case ({alloc_fire, commit_fire})
          2'b10:   cnt_d = cnt_q + CW'(1);
          2'b01:   cnt_d = cnt_q - CW'(1);
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  // State registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      rdy_q     <= '0;
      rd_q      <= '0;
      val_q     <= '0;
      head_q    <= TAG_ONE;
      tail_q    <= TAG_ONE;
      cnt_q     <= '0;
      cm_ena_q  <= FALSE;
      cm_rd_q   <= '0;
      cm_data_q <= '0;
      cm_tag_q  <= '0;
    end else begin
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      rd_q      <= rd_d;
      val_q     <= val_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      cm_ena_q  <= cm_ena_d;
      cm_rd_q   <= cm_rd_d;
      cm_data_q <= cm_data_d;
      cm_tag_q  <= cm_tag_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, CDB capture/forwarding,
// in-order commit, full/wrap behaviour, enable hold and flush.
module tb_reorder_buffer;

  logic        clk, rst, ena, clear, alloc_ena;
  logic [4:0]  alloc_rd;
  logic [3:0]  alloc_tag;
  logic        has_capacity;
  logic [3:0]  alu_cdb_tag, ls_cdb_tag, q1_tag, q2_tag;
  logic [31:0] alu_cdb_data, ls_cdb_data, q1_data, q2_data;
  logic        alu_cdb_isload, q1_ready, q2_ready;
  logic        commit_ena;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [3:0]  commit_tag;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear),
    .alloc_ena(alloc_ena), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
    .has_capacity(has_capacity),
    .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data), .alu_cdb_isload(alu_cdb_isload),
    .ls_cdb_tag(ls_cdb_tag), .ls_cdb_data(ls_cdb_data),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .commit_ena(commit_ena), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_tag(commit_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the active edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    clear = 0; alloc_ena = 0; alloc_rd = 0;
    alu_cdb_tag = 0; alu_cdb_data = 0; alu_cdb_isload = 0;
    ls_cdb_tag = 0; ls_cdb_data = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1; ena = 1;
    tick(); tick();
    rst = 0;
    #1;
  endtask

  task automatic chk_commit(input string tag, input logic [3:0] t, input logic [4:0] rd,
                            input logic [31:0] d);
    chk({tag, ".ena"}, 32'(commit_ena), 32'd1);
    chk({tag, ".tag"}, 32'(commit_tag), 32'(t));
    chk({tag, ".rd"},  32'(commit_rd),  32'(rd));
    chk({tag, ".data"}, commit_data, d);
  endtask

  initial begin
    q1_tag = 0; q2_tag = 0;
    do_reset();

    // Reset state
    chk("rst.alloc_tag", 32'(alloc_tag), 32'd1);
    chk("rst.has_cap", 32'(has_capacity), 32'd1);
    chk("rst.commit_ena", 32'(commit_ena), 32'd0);
    chk("rst.commit_rd", 32'(commit_rd), 32'd0);
    chk("rst.commit_data", commit_data, 32'd0);
    chk("rst.commit_tag", 32'(commit_tag), 32'd0);
    chk("rst.count", 32'(dut.cnt_q), 32'd0);

    // Three allocations, rd 1..3
    for (int i = 1; i <= 3; i++) begin
      alloc_ena = 1; alloc_rd = 5'(i);
      #1;
      chk("alloc3.tag", 32'(alloc_tag), 32'(i));
      tick();
      chk("alloc3.no_commit", 32'(commit_ena), 32'd0);
    end
    alloc_ena = 0;
    #1;
    chk("alloc3.count", 32'(dut.cnt_q), 32'd3);
    chk("alloc3.next_tag", 32'(alloc_tag), 32'd4);
    q1_tag = 0; q2_tag = 2;
    #1;
    chk("q.zero.ready", 32'(q1_ready), 32'd1);
    chk("q.zero.data", q1_data, 32'd0);
    chk("q.pending.ready", 32'(q2_ready), 32'd0);
    chk("q.pending.data", q2_data, 32'd0);

    // Out-of-order results, in-order retirement
    alu_cdb_tag = 2; alu_cdb_data = 32'hAA;
    #1;
    chk("fwd.alu.ready", 32'(q2_ready), 32'd1);
    chk("fwd.alu.data", q2_data, 32'hAA);
    tick();
    alu_cdb_tag = 1; alu_cdb_data = 32'h55;
    tick();
    quiet();
    chk("cdb_same_edge.no_commit", 32'(commit_ena), 32'd0);
    tick();
    chk_commit("commit1", 4'd1, 5'd1, 32'h55);
    tick();
    chk_commit("commit2", 4'd2, 5'd2, 32'hAA);
    tick();
    chk("commit.idle", 32'(commit_ena), 32'd0);
    chk("commit.count", 32'(dut.cnt_q), 32'd1);

    // Fill to capacity from a fresh reset
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      alloc_ena = 1; alloc_rd = 5'(i);
      #1;
      chk("fill.tag", 32'(alloc_tag), 32'(i));
      tick();
    end
    alloc_ena = 0;
    #1;
    chk("full.has_cap", 32'(has_capacity), 32'd0);
    chk("full.count", 32'(dut.cnt_q), 32'd15);
    chk("full.alloc_tag", 32'(alloc_tag), 32'd1);
    alloc_ena = 1; alloc_rd = 5'd31;
    tick();
    alloc_ena = 0;
    chk("full.drop.count", 32'(dut.cnt_q), 32'd15);
    chk("full.drop.tag", 32'(alloc_tag), 32'd1);
    alu_cdb_tag = 1; alu_cdb_data = 32'h11;
    tick();
    // Full + commit: allocation refused this cycle
    alu_cdb_tag = 2; alu_cdb_data = 32'h22; alloc_ena = 1; alloc_rd = 5'd20;
    tick();
    chk_commit("fullcommit", 4'd1, 5'd1, 32'h11);
    chk("fullcommit.count", 32'(dut.cnt_q), 32'd14);
    chk("fullcommit.tag_held", 32'(alloc_tag), 32'd1);
    chk("fullcommit.has_cap", 32'(has_capacity), 32'd1);
    // Commit and allocate together: wrapped tag 1, count unchanged
    quiet();
    alloc_ena = 1; alloc_rd = 5'd21;
    #1;
    chk("wrap.grant_tag", 32'(alloc_tag), 32'd1);
    tick();
    alloc_ena = 0;
    chk_commit("wrapcommit", 4'd2, 5'd2, 32'h22);
    chk("wrap.count", 32'(dut.cnt_q), 32'd14);
    chk("wrap.next_tag", 32'(alloc_tag), 32'd2);

    // Load-flagged ALU broadcast ignored; ls broadcast forwards and captures
    alu_cdb_tag = 4; alu_cdb_data = 32'h99; alu_cdb_isload = 1; q1_tag = 4;
    #1;
    chk("isload.fwd.ready", 32'(q1_ready), 32'd0);
    chk("isload.fwd.data", q1_data, 32'd0);
    tick();
    quiet();
    #1;
    chk("isload.not_captured", 32'(q1_ready), 32'd0);
    ls_cdb_tag = 4; ls_cdb_data = 32'h77;
    #1;
    chk("ls.fwd.ready", 32'(q1_ready), 32'd1);
    chk("ls.fwd.data", q1_data, 32'h77);
    tick();
    quiet();
    #1;
    chk("ls.stored.ready", 32'(q1_ready), 32'd1);
    chk("ls.stored.data", q1_data, 32'h77);

    // Both CDBs name tag 5: ls wins for forwarding and storage
    alu_cdb_tag = 5; alu_cdb_data = 32'h1; ls_cdb_tag = 5; ls_cdb_data = 32'h2; q1_tag = 5;
    #1;
    chk("both.fwd.data", q1_data, 32'h2);
    tick();
    quiet();
    alu_cdb_tag = 3; alu_cdb_data = 32'h33;
    tick();
    quiet();
    tick();
    chk_commit("c3", 4'd3, 5'd3, 32'h33);
    tick();
    chk_commit("c4", 4'd4, 5'd4, 32'h77);
    tick();
    chk_commit("c5", 4'd5, 5'd5, 32'h2);
    tick();
    chk("c.idle", 32'(commit_ena), 32'd0);
    chk("c.count", 32'(dut.cnt_q), 32'd11);

    // Enable low freezes all registered state
    alu_cdb_tag = 6; alu_cdb_data = 32'h66;
    tick();
    quiet();
    ena = 0; alloc_ena = 1; alloc_rd = 5'd9;
    tick();
    alloc_ena = 0;
    chk("hold.count", 32'(dut.cnt_q), 32'd11);
    chk("hold.alloc_tag", 32'(alloc_tag), 32'd2);
    chk("hold.no_commit", 32'(commit_ena), 32'd0);
    ena = 1;
    tick();
    chk_commit("c6", 4'd6, 5'd6, 32'h66);
    ena = 0;
    tick();
    chk("hold.commit_ena", 32'(commit_ena), 32'd1);
    chk("hold.commit_tag", 32'(commit_tag), 32'd6);
    chk("hold.count2", 32'(dut.cnt_q), 32'd10);
    ena = 1;

    // Flush with six busy entries and a ready head
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      alloc_ena = 1; alloc_rd = 5'(i + 10);
      tick();
    end
    quiet();
    alu_cdb_tag = 1; alu_cdb_data = 32'h5A;
    tick();
    quiet();
    chk("preclear.count", 32'(dut.cnt_q), 32'd6);
    clear = 1; alloc_ena = 1; alloc_rd = 5'd7;
    tick();
    quiet();
    chk("clear.count", 32'(dut.cnt_q), 32'd0);
    chk("clear.alloc_tag", 32'(alloc_tag), 32'd1);
    chk("clear.commit_ena", 32'(commit_ena), 32'd0);
    chk("clear.has_cap", 32'(has_capacity), 32'd1);
    q1_tag = 1;
    #1;
    chk("clear.q1_ready", 32'(q1_ready), 32'd0);
    tick();
    chk("clear.no_late_commit", 32'(commit_ena), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
